// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder with a prescaled auto-scan mode.
// Drives display anodes/rows or chip selects; bcode is one-cold when ACTIVE_LOW.
//
// state  | meaning
// DIRECT | bcode/idx follow address a with one cycle of latency
// SCAN   | idx walks 0..last, advancing every tick_div+1 enabled cycles
module decoder_scan_n #(
    parameter int N          = 4,
    parameter int PRESC_W    = 18,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        last,
    input  logic [PRESC_W-1:0]  tick_div,
    output logic [2**N-1:0]     bcode,
    output logic [N-1:0]        idx,
    output logic                scan_tick
);

    localparam int W = 2**N;
    localparam logic [W-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    typedef enum logic {DIRECT, SCAN} state_t;

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [N-1:0]       idx_nxt;
    logic [W-1:0]       bcode_nxt;
    logic               tick_nxt;

    function automatic logic [W-1:0] act(input logic [N-1:0] v);
        logic [W-1:0] oh;
        oh    = '0;
        oh[v] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DIRECT;
            presc     <= '0;
            idx       <= '0;
            bcode     <= INACTIVE;
            scan_tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            idx       <= idx_nxt;
            bcode     <= bcode_nxt;
            scan_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        idx_nxt   = idx;
        bcode_nxt = INACTIVE;
        tick_nxt  = 1'b0;

        if (!mode || state == DIRECT) begin
            // Direct decode and scan entry share the same load of a.
            state_nxt = mode ? SCAN : DIRECT;
            presc_nxt = '0;
            idx_nxt   = a;
            bcode_nxt = en ? act(a) : INACTIVE;
        end else if (en) begin
            // >= so a lowered tick_div fires at once instead of waiting for wrap.
            if (presc >= tick_div) begin
                presc_nxt = '0;
                tick_nxt  = 1'b1;
                idx_nxt   = (idx >= last) ? '0 : idx + N'(1);
                bcode_nxt = act(idx_nxt);
            end else begin
                presc_nxt = presc + PRESC_W'(1);
                bcode_nxt = act(idx);
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed bench for decoder_scan_n: direct decode, scan sequencing, boundaries,
// enable gating, active-low polarity and asynchronous reset.
module tb_decoder_scan_n;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, mode = 1'b0;
    logic [3:0]  a = '0, last = '0;
    logic [17:0] tick_div = '0;
    logic [15:0] bcode;
    logic [3:0]  idx;
    logic        scan_tick;

    logic        en2 = 1'b0, mode2 = 1'b0;
    logic [2:0]  a2 = '0, last2 = '0;
    logic [17:0] tick_div2 = '0;
    logic [7:0]  bcode2;
    logic [2:0]  idx2;
    logic        scan_tick2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    decoder_scan_n #(.N(4), .PRESC_W(18), .ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .last(last),
        .tick_div(tick_div), .bcode(bcode), .idx(idx), .scan_tick(scan_tick)
    );

    decoder_scan_n #(.N(3), .PRESC_W(18), .ACTIVE_LOW(1)) dut_low (
        .clk(clk), .reset(reset), .en(en2), .mode(mode2), .a(a2), .last(last2),
        .tick_div(tick_div2), .bcode(bcode2), .idx(idx2), .scan_tick(scan_tick2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_total++; if (bcode !== 16'h0000) $display("FAIL reset_bcode got %h exp 0000", bcode); else n_pass++;
        n_total++; if (idx !== 4'd0) $display("FAIL reset_idx got %0d exp 0", idx); else n_pass++;
        n_total++; if (scan_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", scan_tick); else n_pass++;
        n_total++; if (bcode2 !== 8'hFF) $display("FAIL reset_bcode_low got %h exp ff", bcode2); else n_pass++;
        step();
        step();
        #2 reset = 1'b0;
    endtask

    task automatic test_direct();
        logic [15:0] exp;
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            step();
            exp = 16'h0001 << i;
            n_total++; if (bcode !== exp) $display("FAIL direct_bcode a=%0d got %h exp %h", i, bcode, exp); else n_pass++;
            n_total++; if (idx !== 4'(i)) $display("FAIL direct_idx got %0d exp %0d", idx, i); else n_pass++;
            n_total++; if (scan_tick !== 1'b0) $display("FAIL direct_tick got %b exp 0", scan_tick); else n_pass++;
        end
        a = 4'd9;
        step();
        n_total++; if (bcode !== 16'h0200) $display("FAIL direct_a9 got %h exp 0200", bcode); else n_pass++;
        en = 1'b0;
        step();
        n_total++; if (bcode !== 16'h0000) $display("FAIL direct_en0 got %h exp 0000", bcode); else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_scan_wrap();
        logic [3:0] seq [5] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
        logic [3:0] ei;
        logic       et;
        logic [15:0] eb;
        tick_div = 18'd2; last = 4'd3; mode = 1'b0; a = 4'd1;
        step();
        mode = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            ei = seq[k / 3];
            et = (k % 3 == 0) && (k != 0);
            eb = 16'h0001 << ei;
            n_total++; if (idx !== ei) $display("FAIL wrap_idx k=%0d got %0d exp %0d", k, idx, ei); else n_pass++;
            n_total++; if (scan_tick !== et) $display("FAIL wrap_tick k=%0d got %b exp %b", k, scan_tick, et); else n_pass++;
            n_total++; if (bcode !== eb) $display("FAIL wrap_bcode k=%0d got %h exp %h", k, bcode, eb); else n_pass++;
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_boundaries();
        // tick_div=0, full-range wrap 15 -> 0
        tick_div = 18'd0; last = 4'd15; a = 4'd14; mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        n_total++; if (idx !== 4'd14 || scan_tick !== 1'b0) $display("FAIL full_entry got idx=%0d tick=%b exp 14/0", idx, scan_tick); else n_pass++;
        step();
        n_total++; if (idx !== 4'd15 || scan_tick !== 1'b1) $display("FAIL full_15 got idx=%0d tick=%b exp 15/1", idx, scan_tick); else n_pass++;
        step();
        n_total++; if (idx !== 4'd0 || scan_tick !== 1'b1 || bcode !== 16'h0001) $display("FAIL full_wrap got idx=%0d tick=%b bcode=%h exp 0/1/0001", idx, scan_tick, bcode); else n_pass++;
        step();
        n_total++; if (idx !== 4'd1 || bcode !== 16'h0002) $display("FAIL full_1 got idx=%0d bcode=%h exp 1/0002", idx, bcode); else n_pass++;

        // last=0: idx pinned at 0, tick every cycle
        mode = 1'b0; a = 4'd0; last = 4'd0;
        step();
        mode = 1'b1;
        step();
        n_total++; if (idx !== 4'd0 || scan_tick !== 1'b0) $display("FAIL last0_entry got idx=%0d tick=%b exp 0/0", idx, scan_tick); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++; if (idx !== 4'd0 || scan_tick !== 1'b1 || bcode !== 16'h0001) $display("FAIL last0 k=%0d got idx=%0d tick=%b bcode=%h exp 0/1/0001", k, idx, scan_tick, bcode); else n_pass++;
        end

        // start above last wraps to 0 on first advance
        mode = 1'b0; a = 4'd10; last = 4'd3;
        step();
        mode = 1'b1;
        step();
        n_total++; if (idx !== 4'd10 || bcode !== 16'h0400) $display("FAIL above_entry got idx=%0d bcode=%h exp 10/0400", idx, bcode); else n_pass++;
        step();
        n_total++; if (idx !== 4'd0 || scan_tick !== 1'b1) $display("FAIL above_wrap got idx=%0d tick=%b exp 0/1", idx, scan_tick); else n_pass++;
        mode = 1'b0;
        step();
    endtask

    task automatic test_enable_gating();
        tick_div = 18'd4; last = 4'd15; a = 4'd0; mode = 1'b0;
        step();
        mode = 1'b1;
        step();
        step();
        step();
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            n_total++; if (bcode !== 16'h0000 || idx !== 4'd0 || scan_tick !== 1'b0) $display("FAIL gate_off k=%0d got bcode=%h idx=%0d tick=%b exp 0000/0/0", k, bcode, idx, scan_tick); else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++; if (bcode !== 16'h0001 || idx !== 4'd0 || scan_tick !== 1'b0) $display("FAIL gate_resume got bcode=%h idx=%0d tick=%b exp 0001/0/0", bcode, idx, scan_tick); else n_pass++;
        step();
        n_total++; if (idx !== 4'd0 || scan_tick !== 1'b0) $display("FAIL gate_count got idx=%0d tick=%b exp 0/0", idx, scan_tick); else n_pass++;
        step();
        n_total++; if (idx !== 4'd1 || scan_tick !== 1'b1 || bcode !== 16'h0002) $display("FAIL gate_advance got idx=%0d tick=%b bcode=%h exp 1/1/0002", idx, scan_tick, bcode); else n_pass++;
        mode = 1'b0;
        step();
    endtask

    task automatic test_active_low();
        en2 = 1'b1; mode2 = 1'b0; a2 = 3'd5;
        step();
        n_total++; if (bcode2 !== 8'hDF || idx2 !== 3'd5) $display("FAIL low_a5 got bcode=%h idx=%0d exp df/5", bcode2, idx2); else n_pass++;
        en2 = 1'b0;
        step();
        n_total++; if (bcode2 !== 8'hFF) $display("FAIL low_en0 got %h exp ff", bcode2); else n_pass++;
    endtask

    task automatic test_async_reset();
        tick_div = 18'd3; last = 4'd7; a = 4'd2; mode = 1'b0; en = 1'b1;
        step();
        mode = 1'b1;
        step();
        step();
        n_total++; if (idx !== 4'd2 || bcode !== 16'h0004) $display("FAIL pre_reset got idx=%0d bcode=%h exp 2/0004", idx, bcode); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++; if (bcode !== 16'h0000 || idx !== 4'd0 || scan_tick !== 1'b0) $display("FAIL async_reset got bcode=%h idx=%0d tick=%b exp 0000/0/0", bcode, idx, scan_tick); else n_pass++;
        mode = 1'b0; a = 4'd6;
        #2 reset = 1'b0;
        step();
        n_total++; if (bcode !== 16'h0040 || idx !== 4'd6 || scan_tick !== 1'b0) $display("FAIL post_reset got bcode=%h idx=%0d tick=%b exp 0040/6/0", bcode, idx, scan_tick); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_boundaries();
        test_enable_gating();
        test_active_low();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised registered N-to-2^N one-hot decoder with an auto-scan mode. In direct mode it decodes an input address, as the gate-level decoders do but generalised to any width and with a registered output. In scan mode an internal prescaled counter cycles the active output through 0..last. It is intended for multiplexed display anode/row drive and for chip-select generation in the prototyping designs.

Parameters:
N, 4, address width; output width is 2**N.
PRESC_W, 18, prescaler counter width.
ACTIVE_LOW, 0, 1 inverts bcode polarity (active output driven 0, all others 1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  global enable; 0 forces all outputs inactive.
mode  input  1  0 = direct decode, 1 = auto-scan.
a  input  N  address (direct mode); start index on entry to scan.
last  input  N  highest scan index; the scan wraps after it.
tick_div  input  PRESC_W  prescaler terminal count; the index advances every tick_div+1 cycles.
bcode  output  2**N  registered one-hot (or one-cold if ACTIVE_LOW) decode.
idx  output  N  index currently driven on bcode.
scan_tick  output  1  one-cycle pulse on the cycle idx advances.

Behaviour:
- Reset (async, active-high, effective immediately):
  - state=DIRECT, prescaler=0, idx=0, scan_tick=0.
  - bcode all inactive: all 0, or all 1 when ACTIVE_LOW.
- All outputs are registered. Define act(v) = 1<<v, inverted bitwise when ACTIVE_LOW; inactive = all-0 (ACTIVE_LOW=0) or all-1 (ACTIVE_LOW=1).
- State DIRECT (mode=0):
  - Each cycle: idx<=a; bcode<=en ? act(a) : inactive.
  - Latency 1 cycle. Prescaler held at 0. scan_tick=0.
- Transition DIRECT->SCAN: on the first cycle mode=1 is sampled.
  - idx<=a, prescaler<=0, bcode<=en ? act(a) : inactive, scan_tick=0.
- State SCAN (mode=1), when en=1:
  - Each cycle, if prescaler>=tick_div:
    - prescaler<=0, scan_tick<=1.
    - idx<=(idx>=last) ? 0 : idx+1.
    - bcode<=act(next idx).
  - Otherwise: prescaler<=prescaler+1, scan_tick<=0, idx and bcode hold.
  - The >= compare means a reduced tick_div mid-count fires on the next cycle rather than waiting for counter overflow.
  - tick_div=0 advances idx every cycle.
- SCAN with en=0:
  - Prescaler and idx frozen; bcode<=inactive; scan_tick<=0.
  - When en returns to 1, bcode<=act(idx) on the next edge and counting resumes from the frozen prescaler value.
- Transition SCAN->DIRECT: on the first cycle mode=0 is sampled, direct behaviour applies immediately. Prescaler<=0, scan_tick<=0.
- Boundary conditions:
  - last=0: idx stays 0 and scan_tick still pulses each period.
  - last=2**N-1: full wrap, so idx=2**N-1 advances to 0 (natural overflow).
  - Start index a>last: the first advance wraps to 0.
  - last changed mid-scan: takes effect at the next advance compare.
- Exactly one bcode bit is active whenever en=1, in both modes. No bit is active when en=0.
- Reset asserted mid-scan aborts the scan: state returns to DIRECT and all reset values apply. After release, the first clock behaves as DIRECT (or enters SCAN if mode=1).

Test Plan:
- Direct decode, N=4: reset, en=1, mode=0, sweep a=0..15 -> bcode=1<<a one cycle later (a=9 gives 16'h0200), idx=a, scan_tick=0; en=0 -> bcode=16'h0000.
- Scan wrap: N=4, tick_div=2, last=3, mode 0->1 with a=1 -> idx sequence 1,2,3,0,1, each held exactly 3 cycles; scan_tick pulses coincide with each idx change; bcode tracks act(idx).
- Boundaries: tick_div=0, last=15 -> idx advances every cycle and wraps 15->0; last=0 -> idx stays 0 with scan_tick every cycle; start a=10 with last=3 -> first advance gives idx=0.
- Enable gating: during scan with tick_div=4, drop en for 7 cycles mid-count -> bcode=16'h0000, idx frozen, no scan_tick; on re-enable bcode=act(idx) after 1 cycle and the remaining count completes before the next advance.
- ACTIVE_LOW=1, N=3: reset -> bcode=8'hFF; direct a=5 -> bcode=8'hDF; en=0 -> 8'hFF.
- Async reset mid-scan (idx=2, prescaler mid-count) asserted between clock edges -> bcode inactive, idx=0, scan_tick=0 immediately without a clock edge; with mode=0 after release, direct decode resumes on the first edge.
